eth_rx_frame_check: RTL
=======================

Name: eth_rx_frame_check

Overview:
- Upstream stage of the RAMP Ethernet receive block; it sits between the GMII receive pins and the packet parser.
- Strips preamble/SFD and forwards payload bytes (dest MAC first) as rxd/rxdv, one byte per clk.
- Runs CRC-32 and length checks over each frame and issues exactly one packetvalid or packetinvalid pulse per forwarded frame. The parser's framecheck states wait on this pulse.

Parameters:
- MIN_FRAME, 64, minimum legal post-SFD byte count including FCS
- MAX_FRAME, 1518, maximum legal post-SFD byte count including FCS

Ports:
- clk  input  1  GMII receive clock; the single clock of the block
- reset  input  1  asynchronous, active-low reset
- gmii_rxd  input  8  raw GMII receive byte
- gmii_rxdv  input  1  GMII receive data valid
- gmii_rxer  input  1  GMII receive error
- rxd  output  8  post-SFD byte to the parser
- rxdv  output  1  post-SFD byte valid
- packetvalid  output  1  one-cycle pulse: frame good
- packetinvalid  output  1  one-cycle pulse: frame bad
- good_cnt  output  16  good-frame count (optional feature)
- bad_cnt  output  16  bad-frame count (optional feature)

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; rxd, rxdv, packetvalid, packetinvalid, good_cnt and bad_cnt all 0; CRC register 0xFFFFFFFF; byte count 0.
- The GMII inputs are registered once before use.
- State machine states: IDLE, PREAMBLE, DATA, REPORT, DROP.
- IDLE:
  - gmii_rxdv=1 with byte 0x55 -> PREAMBLE.
  - gmii_rxdv=1 with byte 0xD5 -> DATA.
  - gmii_rxdv=1 with any other byte -> DROP.
- PREAMBLE:
  - byte 0x55 -> stay.
  - byte 0xD5 -> DATA; CRC loaded with 0xFFFFFFFF and count cleared.
  - any other byte -> DROP.
  - gmii_rxdv=0 -> IDLE, with no pulse.
- DATA:
  - Each valid byte is forwarded on rxd with rxdv=1. Latency from the GMII pins to rxd/rxdv is 2 clk.
  - The CRC is updated with each byte: reflected CRC-32, polynomial 0xEDB88320, LSB first.
  - The byte count increments and saturates at 2047 (11 bits).
  - gmii_rxer=1 at any DATA cycle sets a sticky error flag.
  - gmii_rxdv=0 -> REPORT; rxdv drops in the same cycle.
- REPORT (exactly 1 cycle):
  - The frame is good iff all of the following hold: CRC register == 0xDEBB20E3; MIN_FRAME <= count <= MAX_FRAME; error flag clear.
  - Good frame: packetvalid=1. Otherwise: packetinvalid=1.
  - Next state -> IDLE. REPORT does not wait for or depend on gmii_rxdv.
  - A new frame's first preamble byte arriving during REPORT is held in the input register; it is consumed in IDLE and is not lost.
- DROP:
  - Nothing is forwarded and no pulse is issued.
  - gmii_rxdv=0 -> IDLE.
  - Reset deasserting mid-frame lands in IDLE with a non-preamble byte, so the rest of that frame is silently dropped.
- The FCS bytes are forwarded; the parser uses its own length field and ignores them.
- Consequence for the parser: the single pulse always occurs exactly 1 cycle after rxdv falls.
- packetvalid and packetinvalid are never asserted together.

Optional Feature:
- Macro: ETH_RX_STATS_EN.
- Defined:
  - good_cnt increments on each packetvalid; bad_cnt increments on each packetinvalid.
  - Both counters are 16-bit and saturate at 0xFFFF. Both reset to 0.
- Undefined: good_cnt and bad_cnt are tied to 0 and no counter logic is synthesized.

Decomposition:
- Package libeth holds:
  - state enum eth_rx_fc_state_type;
  - constants CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
- One sub-module, eth_crc32_d8: purely combinational 8-bit-per-step CRC next-state function (crc_in[31:0], data[7:0] -> crc_out[31:0]). It is reused by the transmit-side FCS generator.

Test Plan:
- 7x0x55, 0xD5, 60-byte frame with dest 11:22:33:44:55:66 and type 0x8888, correct FCS (64 bytes) -> 64 rxdv cycles with first rxd=0x11, then one packetvalid exactly 1 cycle after rxdv falls; good_cnt=1 with ETH_RX_STATS_EN.
- Same frame with one payload bit flipped -> packetinvalid pulse, packetvalid never asserted.
- Valid-CRC frame of 63 bytes, and another of 1519 bytes -> packetinvalid for each.
- 64-byte good frame with gmii_rxer=1 for one cycle at byte 20 -> packetinvalid.
- Preamble 0x55,0x55,0x12 then 70 bytes -> rxdv stays 0, no pulse; a following good frame -> packetvalid.
- reset driven low at byte 30 of a frame and released at byte 40 -> all outputs 0 immediately, remainder dropped with no pulse; next frame with a one-cycle gap after REPORT gives packetvalid. Also back-to-back frames with 1 idle cycle give two correct pulses.

Source files
------------

// File: rtl/eth_rx_frame_check_pkg.sv
// Shared Ethernet definitions: receive frame-check FSM states and CRC-32 / framing constants.
package libeth;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StReport,
        StDrop
    } eth_rx_fc_state_type;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_rx_frame_check_crc32_d8.sv
// Combinational reflected CRC-32 step over one byte, LSB first; also used by the TX FCS generator.
module eth_crc32_d8
    import libeth::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
        end
        crc_out = w_crc;
    end

endmodule

// File: rtl/eth_rx_frame_check.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes, reports CRC/length verdict.
// Define ETH_RX_STATS_EN to build the saturating good/bad frame counters.
module eth_rx_frame_check
    import libeth::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rxdv,
    input  logic        gmii_rxer,
    output logic [7:0]  rxd,
    output logic        rxdv,
    output logic        packetvalid,
    output logic        packetinvalid,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);

    eth_rx_fc_state_type r_state, w_state_next;

    logic [7:0]  r_in_rxd;
    logic        r_in_rxdv;
    logic        r_in_rxer;
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [10:0] r_cnt;
    logic        r_err;
    logic        w_start;
    logic        w_fwd;
    logic        w_report;
    logic        w_good;

    eth_crc32_d8 u_crc (
        .crc_in  (r_crc),
        .data    (r_in_rxd),
        .crc_out (w_crc_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_fwd        = 1'b0;
        w_report     = 1'b0;
        unique case (r_state)
            StIdle, StPreamble: begin
                if (!r_in_rxdv) begin
                    w_state_next = StIdle;
                end else if (r_in_rxd == PREAMBLE_BYTE) begin
                    w_state_next = StPreamble;
                end else if (r_in_rxd == SFD_BYTE) begin
                    w_state_next = StData;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = StDrop;
                end
            end
            StData: begin
                if (r_in_rxdv) w_fwd = 1'b1;
                else           w_state_next = StReport;
            end
            StReport: begin
                w_report     = 1'b1;
                w_state_next = StIdle;
            end
            StDrop: begin
                if (!r_in_rxdv) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_good = (r_crc == CRC32_RESIDUE) && (r_cnt >= MIN_CNT) && (r_cnt <= MAX_CNT) && !r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_in_rxd      <= 8'h00;
            r_in_rxdv     <= 1'b0;
            r_in_rxer     <= 1'b0;
            r_crc         <= CRC32_INIT;
            r_cnt         <= 11'd0;
            r_err         <= 1'b0;
            rxd           <= 8'h00;
            rxdv          <= 1'b0;
            packetvalid   <= 1'b0;
            packetinvalid <= 1'b0;
        end else begin
            // Freeze the input stage during the verdict cycle so a back-to-back preamble byte waits for IDLE.
            if (r_state != StReport) begin
                r_in_rxd  <= gmii_rxd;
                r_in_rxdv <= gmii_rxdv;
                r_in_rxer <= gmii_rxer;
            end
            r_state       <= w_state_next;
            rxdv          <= w_fwd;
            packetvalid   <= w_report & w_good;
            packetinvalid <= w_report & ~w_good;
            if (w_fwd) rxd <= r_in_rxd;
            if (w_start) begin
                r_crc <= CRC32_INIT;
                r_cnt <= 11'd0;
                r_err <= 1'b0;
            end else if (w_fwd) begin
                r_crc <= w_crc_next;
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 11'd1;
            end
            if (r_state == StData && r_in_rxer) r_err <= 1'b1;
        end
    end

`ifdef ETH_RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_good_cnt <= 16'h0000;
            r_bad_cnt  <= 16'h0000;
        end else begin
            if (packetvalid && r_good_cnt != 16'hFFFF)  r_good_cnt <= r_good_cnt + 16'd1;
            if (packetinvalid && r_bad_cnt != 16'hFFFF) r_bad_cnt  <= r_bad_cnt + 16'd1;
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`else
    assign good_cnt = 16'h0000;
    assign bad_cnt  = 16'h0000;
`endif

endmodule
